if_fetch_unit: RTL

//  Instruction-fetch stage: owns the PC, issues word fetches to instruction memory over a req/ack

---
 rtl/if_fetch_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake and presents a
// registered PC/instruction pair to IF/ID, with stall holding, a one-entry skid and branch squashing.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_valid_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [ADDR_W-1:0] PC_STEP  = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-1:0] TGT_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [1:0]        state_r,    state_s;
  logic [ADDR_W-1:0] pc_r,       pc_s;
  logic [ADDR_W-1:0] addr_r,     addr_s;
  logic              req_r,      req_s;
  logic              discard_r,  discard_s;
  logic              skid_vld_r, skid_vld_s;
  logic [ADDR_W-1:0] skid_pc_r,  skid_pc_s;
  logic [INST_W-1:0] skid_inst_r, skid_inst_s;
  logic [ADDR_W-1:0] out_pc_r,   out_pc_s;
  logic [INST_W-1:0] out_inst_r, out_inst_s;
  logic              out_vld_r,  out_vld_s;
  logic              ack_s;
  logic              new_req_s;
  logic [ADDR_W-1:0] tgt_s;

  assign ack_s = imem_ack_i & (state_r == ST_REQ);
  assign tgt_s = branch_target_i & TGT_MASK;

  // Next-state, PC, skid and presented-output computation; a branch overrides everything else.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    discard_s   = discard_r;
    skid_vld_s  = skid_vld_r;
    skid_pc_s   = skid_pc_r;
    skid_inst_s = skid_inst_r;
    out_pc_s    = out_pc_r;
    out_inst_s  = out_inst_r;
    out_vld_s   = out_vld_r;

    case (state_r)
      ST_IDLE: begin
        state_s    = ST_REQ;
        out_vld_s  = 1'b0;
        out_inst_s = {INST_W{1'b0}};
      end
      ST_REQ: begin
        if (ack_s && discard_r) begin
          // Response to a fetch issued before a redirect: drop it, pc already holds the target.
          discard_s = 1'b0;
          if (!stall_i) begin
            out_vld_s  = 1'b0;
            out_inst_s = {INST_W{1'b0}};
          end else begin
            out_vld_s  = out_vld_r;
          end
        end else if (ack_s) begin
          pc_s = pc_r + PC_STEP;
          if (stall_i) begin
            state_s = ST_HOLD;
            if (out_vld_r) begin
              skid_vld_s  = 1'b1;
              skid_pc_s   = pc_r;
              skid_inst_s = imem_rdata_i;
            end else begin
              out_vld_s  = 1'b1;
              out_pc_s   = pc_r;
              out_inst_s = imem_rdata_i;
            end
          end else begin
            out_vld_s  = 1'b1;
            out_pc_s   = pc_r;
            out_inst_s = imem_rdata_i;
          end
        end else begin
          if (!stall_i) begin
            out_vld_s  = 1'b0;
            out_inst_s = {INST_W{1'b0}};
          end else begin
            out_vld_s  = out_vld_r;
          end
        end
      end
      ST_HOLD: begin
        if (!stall_i) begin
          state_s = ST_REQ;
          if (skid_vld_r) begin
            skid_vld_s = 1'b0;
            out_vld_s  = 1'b1;
            out_pc_s   = skid_pc_r;
            out_inst_s = skid_inst_r;
          end else begin
            out_vld_s  = 1'b0;
            out_inst_s = {INST_W{1'b0}};
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        out_vld_s  = 1'b0;
        out_inst_s = {INST_W{1'b0}};
      end
    endcase

    if (branch_flag_i) begin
      pc_s       = tgt_s;
      state_s    = ST_REQ;
      skid_vld_s = 1'b0;
      out_vld_s  = 1'b0;
      out_inst_s = {INST_W{1'b0}};
      // An unanswered request cannot be withdrawn, so its eventual response is marked for dropping.
      if ((state_r == ST_REQ) && !ack_s) begin
        discard_s = 1'b1;
      end else begin
        discard_s = 1'b0;
      end
    end else begin
      discard_s = discard_s;
    end
  end

  // Request address only moves when a new request begins; it stays put across wait states.
  always_comb begin
    new_req_s = (state_s == ST_REQ) && ((state_r != ST_REQ) || ack_s);
    req_s     = (state_s == ST_REQ);
    if (new_req_s) begin
      addr_s = pc_s;
    end else begin
      addr_s = addr_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC;
      addr_r      <= RESET_PC;
      req_r       <= 1'b0;
      discard_r   <= 1'b0;
      skid_vld_r  <= 1'b0;
      skid_pc_r   <= {ADDR_W{1'b0}};
      skid_inst_r <= {INST_W{1'b0}};
      out_pc_r    <= {ADDR_W{1'b0}};
      out_inst_r  <= {INST_W{1'b0}};
      out_vld_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      addr_r      <= addr_s;
      req_r       <= req_s;
      discard_r   <= discard_s;
      skid_vld_r  <= skid_vld_s;
      skid_pc_r   <= skid_pc_s;
      skid_inst_r <= skid_inst_s;
      out_pc_r    <= out_pc_s;
      out_inst_r  <= out_inst_s;
      out_vld_r   <= out_vld_s;
    end
  end

  assign imem_req_o  = req_r;
  assign imem_addr_o = addr_r;
  assign if_pc_o     = out_pc_r;
  assign if_inst_o   = out_inst_r;
  assign if_valid_o  = out_vld_r;

endmodule
